// File: rtl/traffic_ctrl_nway.sv
// Round-robin traffic-light sequencer for 2-4 directions. It runs on a one-second tick enable.
// It adds a flashing-green phase, an all-red clearance phase, pedestrian shortening and night flashing.
module traffic_ctrl_nway #(
  parameter int unsigned NUM_DIR     = 2,
  parameter int unsigned T_GREEN     = 20,
  parameter int unsigned T_FLASH     = 5,
  parameter int unsigned T_YELLOW    = 4,
  parameter int unsigned T_ALLRED    = 1,
  parameter int unsigned T_PED_GREEN = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sec_tick,
  input  logic                 day_night,
  input  logic [NUM_DIR-1:0]   ped_req,
  output logic [3*NUM_DIR-1:0] light_led,
  output logic [1:0]           active_dir,
  output logic [7:0]           cnt_bcd,
  output logic [NUM_DIR-1:0]   ped_wait
);

  typedef enum logic [2:0] {StGreen, StFlash, StYellow, StAllred, StNight} state_e;

  localparam logic [6:0] TGreen    = 7'(T_GREEN);
  localparam logic [6:0] TFlash    = 7'(T_FLASH);
  localparam logic [6:0] TYellow   = 7'(T_YELLOW);
  localparam logic [6:0] TAllred   = 7'(T_ALLRED);
  localparam logic [6:0] TPedGreen = 7'(T_PED_GREEN);
  localparam logic [1:0] LastDir   = 2'(NUM_DIR - 1);

  state_e             state_q, state_d;
  logic [6:0]         ptimer_q, ptimer_d;
  logic [1:0]         dir_q, dir_d;
  logic [NUM_DIR-1:0] pend_q, pend_d;
  logic               flash_q, flash_d;

  logic [NUM_DIR-1:0] active_oh;
  logic [1:0]         dir_next;
  logic               enter_green;
  logic               clamp;

  always_comb begin
    active_oh = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      active_oh[d] = (dir_q == 2'(d));
    end
  end

  assign dir_next = (dir_q == LastDir) ? 2'd0 : dir_q + 2'd1;
  assign clamp    = (|(pend_q & ~active_oh)) && (ptimer_q > TPedGreen);

  always_comb begin
    state_d     = state_q;
    ptimer_d    = ptimer_q;
    dir_d       = dir_q;
    flash_d     = flash_q;
    enter_green = 1'b0;
    // The direction holding green never latches its own request.
    pend_d = pend_q | (ped_req & ~(((state_q == StGreen) || (state_q == StFlash)) ?
                                   active_oh : '0));
    if (!day_night) begin
      state_d = StNight;
      if (sec_tick && (state_q == StNight)) flash_d = ~flash_q;
    end else if (state_q == StNight) begin
      if (T_ALLRED != 0) begin
        state_d  = StAllred;
        ptimer_d = TAllred;
        dir_d    = LastDir;
      end else begin
        dir_d       = 2'd0;
        enter_green = 1'b1;
      end
    end else if (sec_tick) begin
      if (state_q == StFlash) flash_d = ~flash_q;
      if (ptimer_q == 7'd1) begin
        unique case (state_q)
          StGreen: begin
            if (T_FLASH != 0) begin
              state_d  = StFlash;
              ptimer_d = TFlash;
              flash_d  = 1'b1;
            end else begin
              state_d  = StYellow;
              ptimer_d = TYellow;
            end
          end
          StFlash: begin
            state_d  = StYellow;
            ptimer_d = TYellow;
          end
          StYellow: begin
            if (T_ALLRED != 0) begin
              state_d  = StAllred;
              ptimer_d = TAllred;
            end else begin
              dir_d       = dir_next;
              enter_green = 1'b1;
            end
          end
          default: begin
            dir_d       = dir_next;
            enter_green = 1'b1;
          end
        endcase
      end else begin
        ptimer_d = ptimer_q - 7'd1;
      end
    end else if ((state_q == StGreen) && clamp) begin
      ptimer_d = TPedGreen;
    end

    if (enter_green) begin
      state_d  = StGreen;
      ptimer_d = TGreen;
      for (int d = 0; d < NUM_DIR; d++) begin
        if (dir_d == 2'(d)) pend_d[d] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StGreen;
      ptimer_q <= TGreen;
      dir_q    <= 2'd0;
      pend_q   <= '0;
      flash_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptimer_q <= ptimer_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      flash_q  <= flash_d;
    end
  end

  always_comb begin
    light_led = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      unique case (state_q)
        StGreen:  light_led[3*d +: 3] = active_oh[d] ? 3'b001 : 3'b100;
        StFlash:  light_led[3*d +: 3] = active_oh[d] ? {2'b00, flash_q} : 3'b100;
        StYellow: light_led[3*d +: 3] = active_oh[d] ? 3'b010 : 3'b100;
        StAllred: light_led[3*d +: 3] = 3'b100;
        default:  light_led[3*d +: 3] = {1'b0, flash_q, 1'b0};
      endcase
    end
  end

  logic [6:0] cnt_bin;
  always_comb begin
    unique case (state_q)
      StGreen:  cnt_bin = ptimer_q + TFlash + TYellow;
      StFlash:  cnt_bin = ptimer_q + TYellow;
      StYellow: cnt_bin = ptimer_q;
      default:  cnt_bin = 7'd0;
    endcase
    cnt_bcd = {4'(cnt_bin / 7'd10), 4'(cnt_bin % 7'd10)};
  end

  assign active_dir = dir_q;
  assign ped_wait   = pend_q;

endmodule
